// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and prefetch buffer feeding decode; optional IFETCH_PERF_EN adds perf counters
module inst_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
`ifdef IFETCH_PERF_EN
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_bubble_count,
`endif
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [63:0] i_branch_target,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic [63:0] o_inst_pc,
    output logic        o_inst_valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;
    state_t        r_state, w_next;
    logic [63:0]   r_pc, r_addr;
    logic [31:0]   r_fifo_inst [FIFO_DEPTH];
    logic [63:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0]   r_count;
    logic          w_accept, w_push, w_pop;
    // A request is only raised with a free slot reserved, so every accepted word can be pushed
    assign w_accept     = o_imem_req && i_imem_ready;
    assign w_push       = (r_state == S_WAIT) && i_imem_rvalid && !i_branch_taken;
    assign w_pop        = (r_count != '0) && !i_stall && !i_branch_taken;
    assign o_imem_addr  = r_pc;
    assign o_inst_valid = r_count != '0;
    assign o_inst       = o_inst_valid ? r_fifo_inst[r_rd] : NOP_INST;
    assign o_inst_pc    = o_inst_valid ? r_fifo_pc[r_rd] : 64'h0;
    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    // Next state and memory request; a redirect withdraws any unaccepted request
    always_comb begin
        w_next     = r_state;
        o_imem_req = (r_state == S_IDLE) && (r_count < DEPTH_C) && !i_branch_taken;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_WAIT : S_IDLE;
            S_WAIT:  w_next = i_imem_rvalid ? S_IDLE : (i_branch_taken ? S_DRAIN : S_WAIT);
            S_DRAIN: w_next = i_imem_rvalid ? S_IDLE : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
    end
    // PC advances on accept, jumps on redirect; in-flight address kept for tagging the response
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc   <= RESET_PC;
            r_addr <= RESET_PC;
        end else if (i_branch_taken) begin
            r_pc <= {i_branch_target[63:2], 2'b00};
        end else if (w_accept) begin
            r_pc   <= r_pc + 64'd4;
            r_addr <= r_pc;
        end
    end
    // Buffer pointers and occupancy; redirect flushes everything
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_branch_taken) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    // Buffer storage
    always_ff @(posedge i_clk) begin
        if (i_reset && w_push) begin
            r_fifo_inst[r_wr] <= i_imem_rdata;
            r_fifo_pc[r_wr]   <= r_addr;
        end
    end
`ifdef IFETCH_PERF_EN
    // Pushed-word and unstalled-empty-cycle counters, survive redirects
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_fetch_count  <= '0;
            o_bubble_count <= '0;
        end else begin
            o_fetch_count  <= o_fetch_count + 32'(w_push);
            o_bubble_count <= o_bubble_count + 32'(!o_inst_valid && !i_stall);
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: random stimulus against a queue-based fetch model
module tb_inst_fetch;
    localparam int          DEPTH = 2;
    localparam logic [63:0] RPC   = 64'h0;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst_n, stall, br, req, ready, rvalid, valid;
    logic [63:0] tgt, addr, ipc;
    logic [31:0] rdata, inst;
`ifdef IFETCH_PERF_EN
    logic [31:0] fcnt, bcnt;
`endif
    always #5 clk = ~clk;
    inst_fetch dut (
        .i_clk(clk), .i_reset(rst_n),
`ifdef IFETCH_PERF_EN
        .o_fetch_count(fcnt), .o_bubble_count(bcnt),
`endif
        .i_stall(stall), .i_branch_taken(br), .i_branch_target(tgt),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_ready(ready),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_inst(inst), .o_inst_pc(ipc), .o_inst_valid(valid)
    );
    typedef struct packed {logic [31:0] w; logic [63:0] a;} ent_t;
    ent_t        q[$];
    logic [63:0] m_pc, m_addr;
    logic [31:0] m_fc, m_bc;
    bit          m_busy, m_stale, m_post_rst;
    int          m_lat, n_chk, n_fail;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction
    task automatic model_reset();
        q.delete();
        m_pc = RPC; m_addr = RPC; m_busy = 0; m_stale = 0; m_lat = 0;
        m_fc = 0; m_bc = 0; m_post_rst = 1;
    endtask
    task automatic run_cycle(input int p_stall, input int p_br, input int p_ready, input int p_rst);
        bit exp_req, rv, acc;
        @(negedge clk);
        rst_n  = $urandom_range(999) >= p_rst;
        stall  = $urandom_range(99) < p_stall;
        br     = $urandom_range(99) < p_br;
        ready  = $urandom_range(99) < p_ready;
        case ($urandom_range(3))
            0: tgt = 64'h103;
            1: tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
            2: tgt = {$urandom, $urandom};
            default: tgt = 64'h100;
        endcase
        rvalid = m_busy ? (m_lat == 0) : ($urandom_range(9) == 0);
        rdata  = (m_busy && !m_stale) ? word_at(m_addr) : $urandom;
        #1;
        exp_req = !m_busy && q.size() < DEPTH && !br;
        check("inst_valid", 64'(valid), 64'(q.size() != 0));
        check("inst", 64'(inst), 64'(q.size() != 0 ? q[0].w : NOP));
        check("inst_pc", ipc, q.size() != 0 ? q[0].a : 64'h0);
        check("imem_req", 64'(req), 64'(exp_req));
        if (exp_req || m_post_rst) check("imem_addr", addr, m_pc);
`ifdef IFETCH_PERF_EN
        check("fetch_count", 64'(fcnt), 64'(m_fc));
        check("bubble_count", 64'(bcnt), 64'(m_bc));
`endif
        @(posedge clk);
        m_post_rst = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rv  = m_busy && rvalid;
        acc = exp_req && ready;
        if (q.size() == 0 && !stall) m_bc++;
        if (br) begin
            q.delete();
            m_pc = tgt & ~64'h3;
            if (rv) begin m_busy = 0; m_stale = 0; end
            else if (m_busy) m_stale = 1;
        end else begin
            if (q.size() != 0 && !stall) void'(q.pop_front());
            if (rv) begin
                if (!m_stale) begin q.push_back({rdata, m_addr}); m_fc++; end
                m_busy = 0; m_stale = 0;
            end
            if (acc) begin
                m_busy = 1; m_stale = 0; m_addr = m_pc; m_pc = m_pc + 64'd4;
                m_lat = $urandom_range(3);
            end
        end
        if (m_busy && !acc && !rv && m_lat > 0) m_lat--;
    endtask
    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 0; stall = 0; br = 0; ready = 0; rvalid = 0; tgt = '0; rdata = '0;
        repeat (2) @(posedge clk);
        model_reset();
        for (int i = 0; i < 400; i++) run_cycle(0, 0, 100, 0);
        for (int i = 0; i < 400; i++) run_cycle(70, 0, 60, 5);
        for (int i = 0; i < 600; i++) run_cycle(30, 15, 50, 5);
        for (int i = 0; i < 600; i++) run_cycle(50, 30, 30, 10);
        for (int i = 0; i < 300; i++) run_cycle(10, 5, 90, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
